// File: rtl/led_chaser.sv
// One-hot LED chaser with an optional blank slot in the ring, a programmable prescaler,
// forward/reverse/bounce stepping, pause, position preload and step/wrap status pulses.
module led_chaser #(
  parameter int N_LED         = 8,
  parameter int CNT_W         = 8,
  parameter int INCLUDE_BLANK = 1,
  parameter int POS_W         = $clog2(N_LED + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               pause,
  input  logic [CNT_W-1:0]   maximum,
  input  logic               load,
  input  logic [POS_W-1:0]   load_pos,
  output logic [N_LED-1:0]   led,
  output logic               step,
  output logic               wrap
);

  localparam int P = N_LED + ((INCLUDE_BLANK != 0) ? 1 : 0);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(P - 1);
  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0] POS_BLANK = POS_W'(N_LED);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] POS_RST   = (INCLUDE_BLANK != 0) ? POS_BLANK : '0;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_FWD    = 2'b01,
    MODE_REV    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [N_LED-1:0] decode(input logic [POS_W-1:0] p);
    logic [N_LED-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      if (p == POS_W'(i)) d[i] = 1'b1;
    end
    return d;
  endfunction

  mode_e            mode_sel;
  dir_e             dir, dir_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic             running, tick, step_nxt, wrap_nxt;

  assign mode_sel = mode_e'(mode);
  assign running  = (mode != 2'b00) && !pause;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      pos  <= POS_RST;
      dir  <= DIR_UP;
      led  <= decode(POS_RST);
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      pos  <= pos_nxt;
      dir  <= dir_nxt;
      led  <= decode(pos_nxt);
      step <= step_nxt;
      wrap <= wrap_nxt;
    end
  end

  always_comb begin
    cnt_nxt  = cnt;
    pos_nxt  = pos;
    dir_nxt  = dir;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    tick     = 1'b0;
    if (mode_sel != MODE_BOUNCE) dir_nxt = DIR_UP;
    if (load) begin
      pos_nxt = (load_pos > POS_LAST) ? POS_LAST : load_pos;
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (running) begin
      // >= rather than == so lowering maximum below cnt ticks at once
      tick    = (cnt >= maximum);
      cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        step_nxt = 1'b1;
        case (mode_sel)
          MODE_FWD: begin
            if (pos >= POS_LAST) begin
              pos_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              pos_nxt = pos + POS_ONE;
            end
          end
          MODE_REV: begin
            if (pos == '0) begin
              pos_nxt  = POS_LAST;
              wrap_nxt = 1'b1;
            end else begin
              pos_nxt = pos - POS_ONE;
            end
          end
          MODE_BOUNCE: begin
            if (pos >= POS_BLANK) begin
              pos_nxt = '0;
              dir_nxt = DIR_UP;
            end else if (dir == DIR_UP) begin
              // a preload can leave dir up at the top end; reverse there instead of entering blank
              if (pos == POS_TOP) begin
                pos_nxt  = pos - POS_ONE;
                dir_nxt  = DIR_DOWN;
                wrap_nxt = 1'b1;
              end else begin
                pos_nxt = pos + POS_ONE;
                if (pos + POS_ONE == POS_TOP) begin
                  dir_nxt  = DIR_DOWN;
                  wrap_nxt = 1'b1;
                end
              end
            end else begin
              if (pos == '0) begin
                pos_nxt  = POS_ONE;
                dir_nxt  = DIR_UP;
                wrap_nxt = 1'b1;
              end else begin
                pos_nxt = pos - POS_ONE;
                if (pos == POS_ONE) begin
                  dir_nxt  = DIR_UP;
                  wrap_nxt = 1'b1;
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
